// File: rtl/vfu_slot_arbiter_pkg.sv
// Shared definitions for the VFU slot arbiter: default sizing and the
// request payload layout presented to the VFU.
package vfu_slot_arbiter_pkg;

  localparam int unsigned NUM_SLOTS    = 4;
  localparam int unsigned PAYLOAD_W    = 192;
  localparam int unsigned MAX_INFLIGHT = 4;
  localparam int unsigned TAG_W        = $clog2(NUM_SLOTS);
  localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1);

  // One request as seen by the VFU: originating slot plus its payload.
  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;
  } vfu_req_t;

endpackage

// File: rtl/vfu_slot_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i   : per-slot request vector
//   last_i  : index of the most recent winner; search starts one past it
//   grant_o : one-hot winner, all zero when no request is pending
module vfu_slot_arbiter_rr_arbiter
  import vfu_slot_arbiter_pkg::*;
#(
  parameter  int unsigned N_SLOTS = NUM_SLOTS,
  localparam int unsigned IDX_W   = $clog2(N_SLOTS)
) (
  input  logic [N_SLOTS-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [N_SLOTS-1:0] grant_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Walk last+1, last+2, ... wrapping; the first requester wins.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N_SLOTS; k++) begin
      idx = IDX_W'((32'(last_i) + k) % N_SLOTS);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vfu_slot_arbiter.sv
// Shares one VFU among NUM_SLOTS requesters with round-robin arbitration,
// a registered output stage and credit-based limiting of outstanding work.
//   clock, reset          : single clock, async active-high reset
//   in_valid/in_ready     : per-slot request handshake (in_ready combinational)
//   in_payload            : slot i at [i*PAYLOAD_W +: PAYLOAD_W]
//   out_valid/out_ready   : registered request toward the VFU
//   out_payload, out_tag  : registered request body and originating slot
//   resp_valid, resp_tag  : VFU completion strobe (no backpressure)
//   slot_resp_valid       : completion routed one-hot to the slot (combinational)
//   inflight              : requests accepted by the VFU and not yet completed
//   err_underflow         : sticky, completion seen with nothing outstanding
module vfu_slot_arbiter
  import vfu_slot_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS    = vfu_slot_arbiter_pkg::NUM_SLOTS,
  parameter  int unsigned PAYLOAD_W    = vfu_slot_arbiter_pkg::PAYLOAD_W,
  parameter  int unsigned MAX_INFLIGHT = vfu_slot_arbiter_pkg::MAX_INFLIGHT,
  localparam int unsigned T_W          = $clog2(NUM_SLOTS),
  localparam int unsigned C_W          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_SLOTS-1:0]           in_valid,
  output logic [NUM_SLOTS-1:0]           in_ready,
  input  logic [NUM_SLOTS*PAYLOAD_W-1:0] in_payload,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PAYLOAD_W-1:0]           out_payload,
  output logic [T_W-1:0]                 out_tag,
  input  logic                           resp_valid,
  input  logic [T_W-1:0]                 resp_tag,
  output logic [NUM_SLOTS-1:0]           slot_resp_valid,
  output logic [C_W-1:0]                 inflight,
  output logic                           err_underflow
);

  logic                 out_valid_q,   out_valid_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [T_W-1:0]       out_tag_q,     out_tag_d;
  logic [T_W-1:0]       last_grant_q,  last_grant_d;
  logic [C_W-1:0]       inflight_q,    inflight_d;
  logic                 err_q,         err_d;

  logic [NUM_SLOTS-1:0] rr_grant;
  logic [T_W-1:0]       win_idx;
  logic [C_W:0]         committed;
  logic                 load_c, credit_c, grant_c, fire_c, drain_c;

  vfu_slot_arbiter_rr_arbiter #(
    .N_SLOTS (NUM_SLOTS)
  ) u_rr_arbiter (
    .req_i   (in_valid),
    .last_i  (last_grant_q),
    .grant_o (rr_grant)
  );

  // Credit counts the request held in the output stage as already spent.
  assign load_c    = ~out_valid_q | out_ready;
  assign committed = (C_W+1)'(inflight_q) + (C_W+1)'(out_valid_q);
  assign credit_c  = committed < (C_W+1)'(MAX_INFLIGHT);
  assign grant_c   = ~reset & load_c & credit_c & (|in_valid);
  assign in_ready  = grant_c ? rr_grant : '0;

  assign fire_c  = out_valid_q & out_ready;
  assign drain_c = resp_valid & (inflight_q != '0);

  // One-hot winner to index.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (rr_grant[i]) win_idx = T_W'(i);
    end
  end

  // Completion routing.
  always_comb begin
    slot_resp_valid = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_resp_valid[i] = resp_valid & (resp_tag == T_W'(i));
    end
  end

  // Output stage and arbitration pointer.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    out_tag_d     = out_tag_q;
    last_grant_d  = last_grant_q;
    if (grant_c) begin
      out_valid_d   = 1'b1;
      out_payload_d = in_payload[win_idx*PAYLOAD_W +: PAYLOAD_W];
      out_tag_d     = win_idx;
      last_grant_d  = win_idx;
    end else if (fire_c) begin
      out_valid_d   = 1'b0;
    end
  end

  // Outstanding-request counter and underflow flag.
  always_comb begin
    inflight_d = inflight_q;
    unique case ({fire_c, drain_c})
      2'b10:   inflight_d = inflight_q + C_W'(1);
      2'b01:   inflight_d = inflight_q - C_W'(1);
      default: inflight_d = inflight_q;
    endcase
    err_d = err_q | (resp_valid & (inflight_q == '0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      out_tag_q     <= '0;
      last_grant_q  <= T_W'(NUM_SLOTS - 1);
      inflight_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
      out_tag_q     <= out_tag_d;
      last_grant_q  <= last_grant_d;
      inflight_q    <= inflight_d;
      err_q         <= err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_payload   = out_payload_q;
  assign out_tag       = out_tag_q;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_vfu_slot_arbiter.sv
// Directed bench for vfu_slot_arbiter with hand-computed expectations.
module tb_vfu_slot_arbiter;
  import vfu_slot_arbiter_pkg::*;

  localparam int unsigned NS = NUM_SLOTS;
  localparam int unsigned PW = PAYLOAD_W;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NS-1:0]        in_valid;
  logic [NS-1:0]        in_ready;
  logic [NS*PW-1:0]     in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [PW-1:0]        out_payload;
  logic [TAG_W-1:0]     out_tag;
  logic                 resp_valid;
  logic [TAG_W-1:0]     resp_tag;
  logic [NS-1:0]        slot_resp_valid;
  logic [CNT_W-1:0]     inflight;
  logic                 err_underflow;

  int n_chk = 0;
  int n_bad = 0;
  int rr_inf_exp [8] = '{0, 1, 2, 2, 2, 2, 1, 0};

  vfu_slot_arbiter #(
    .NUM_SLOTS    (NS),
    .PAYLOAD_W    (PW),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_payload      (in_payload),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_payload     (out_payload),
    .out_tag         (out_tag),
    .resp_valid      (resp_valid),
    .resp_tag        (resp_tag),
    .slot_resp_valid (slot_resp_valid),
    .inflight        (inflight),
    .err_underflow   (err_underflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pl(input int i, input int salt);
    return {64'hC0DE_0000_0000_0000 + 64'(i), 64'h1234_5678_9ABC_DEF0 ^ 64'(salt), 64'(i * 17 + salt + 1)};
  endfunction

  function automatic logic [NS-1:0] oh(input int i);
    return NS'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = '0;
    out_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_tag   = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = '1;
    out_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_tag   = '0;
    for (int i = 0; i < int'(NS); i++) in_payload[i*PW +: PW] = pl(i, 0);

    // Reset state, requests present while reset is held.
    #1;
    check_eq("rst_in_ready",    256'(in_ready),      256'(0));
    check_eq("rst_out_valid",   256'(out_valid),     256'(0));
    check_eq("rst_out_payload", 256'(out_payload),   256'(0));
    check_eq("rst_out_tag",     256'(out_tag),       256'(0));
    check_eq("rst_inflight",    256'(inflight),      256'(0));
    check_eq("rst_err",         256'(err_underflow), 256'(0));
    tick();
    tick();
    check_eq("rst_in_ready_clk", 256'(in_ready), 256'(0));
    reset = 1'b0;

    // Round-robin with all slots valid, responses two cycles after acceptance.
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid   = (c < 5) ? '1 : '0;
      resp_valid = (c >= 3);
      resp_tag   = (c >= 3) ? TAG_W'((c - 3) % 4) : '0;
      #1;
      if (c < 5)  check_eq("rr_in_ready", 256'(in_ready), 256'(oh(c % 4)));
      if (c >= 3) check_eq("rr_slot_resp", 256'(slot_resp_valid), 256'(oh((c - 3) % 4)));
      tick();
      if (c < 5) begin
        check_eq("rr_out_valid",   256'(out_valid),   256'(1));
        check_eq("rr_out_tag",     256'(out_tag),     256'(c % 4));
        check_eq("rr_out_payload", 256'(out_payload), 256'(pl(c % 4, 0)));
      end
      check_eq("rr_inflight", 256'(inflight), 256'(rr_inf_exp[c]));
    end
    resp_valid = 1'b0;
    check_eq("rr_drain_valid", 256'(out_valid),     256'(0));
    check_eq("rr_drain_err",   256'(err_underflow), 256'(0));

    // Single slot stalled by the VFU: output held, no further grants.
    do_reset();
    in_valid  = NS'(4'b0100);
    out_ready = 1'b0;
    #1;
    check_eq("stall_first_grant", 256'(in_ready), 256'(oh(2)));
    tick();
    check_eq("stall_out_valid", 256'(out_valid), 256'(1));
    check_eq("stall_out_tag",   256'(out_tag),   256'(2));
    in_payload[2*PW +: PW] = pl(2, 5);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("stall_in_ready", 256'(in_ready), 256'(0));
      tick();
      check_eq("stall_hold_valid",   256'(out_valid),   256'(1));
      check_eq("stall_hold_tag",     256'(out_tag),     256'(2));
      check_eq("stall_hold_payload", 256'(out_payload), 256'(pl(2, 0)));
    end
    out_ready = 1'b1;
    #1;
    check_eq("stall_release_ready", 256'(in_ready), 256'(oh(2)));
    tick();
    check_eq("stall_new_payload", 256'(out_payload), 256'(pl(2, 5)));
    check_eq("stall_inflight1",   256'(inflight),    256'(1));
    in_valid = '0;
    tick();
    check_eq("stall_drained_valid", 256'(out_valid), 256'(0));
    check_eq("stall_inflight2",     256'(inflight),  256'(2));
    resp_valid = 1'b1;
    resp_tag   = TAG_W'(2);
    tick();
    tick();
    resp_valid = 1'b0;
    check_eq("stall_inflight0", 256'(inflight), 256'(0));
    in_payload[2*PW +: PW] = pl(2, 0);

    // Credit limit: four issues, then blocked until one completion.
    do_reset();
    in_valid  = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq("cred_in_ready", 256'(in_ready), (c < 4) ? 256'(oh(c)) : 256'(0));
      tick();
    end
    check_eq("cred_inflight_max", 256'(inflight),  256'(4));
    check_eq("cred_out_valid",    256'(out_valid), 256'(0));
    resp_valid = 1'b1;
    resp_tag   = TAG_W'(0);
    #1;
    check_eq("cred_slot_resp",     256'(slot_resp_valid), 256'(oh(0)));
    check_eq("cred_no_bypass",     256'(in_ready),        256'(0));
    tick();
    resp_valid = 1'b0;
    check_eq("cred_inflight3", 256'(inflight), 256'(3));
    #1;
    check_eq("cred_regrant", 256'(in_ready), 256'(oh(0)));
    tick();
    check_eq("cred_regrant_tag", 256'(out_tag),  256'(0));
    check_eq("cred_inflight3b",  256'(inflight), 256'(3));
    #1;
    check_eq("cred_blocked_again", 256'(in_ready), 256'(0));
    tick();
    check_eq("cred_inflight4", 256'(inflight), 256'(4));

    // Simultaneous issue and completion leaves the count unchanged.
    in_valid   = '0;
    resp_valid = 1'b1;
    resp_tag   = TAG_W'(1);
    tick();
    resp_tag   = TAG_W'(2);
    tick();
    resp_valid = 1'b0;
    check_eq("sim_inflight_pre", 256'(inflight), 256'(2));
    in_valid = NS'(4'b0010);
    #1;
    check_eq("sim_grant", 256'(in_ready), 256'(oh(1)));
    tick();
    check_eq("sim_out_tag", 256'(out_tag), 256'(1));
    in_valid   = '0;
    resp_valid = 1'b1;
    resp_tag   = TAG_W'(3);
    #1;
    check_eq("sim_slot_resp", 256'(slot_resp_valid), 256'(oh(3)));
    tick();
    resp_valid = 1'b0;
    check_eq("sim_inflight_same", 256'(inflight),  256'(2));
    check_eq("sim_out_cleared",   256'(out_valid), 256'(0));
    resp_valid = 1'b1;
    resp_tag   = TAG_W'(0);
    tick();
    resp_tag   = TAG_W'(1);
    tick();
    resp_valid = 1'b0;
    check_eq("sim_inflight_zero", 256'(inflight),      256'(0));
    check_eq("sim_no_err",        256'(err_underflow), 256'(0));

    // Completion with nothing outstanding.
    resp_valid = 1'b1;
    resp_tag   = TAG_W'(2);
    #1;
    check_eq("uf_slot_resp", 256'(slot_resp_valid), 256'(oh(2)));
    tick();
    resp_valid = 1'b0;
    check_eq("uf_err",      256'(err_underflow), 256'(1));
    check_eq("uf_inflight", 256'(inflight),      256'(0));
    tick();
    tick();
    check_eq("uf_err_sticky", 256'(err_underflow), 256'(1));

    // Reset in mid-operation.
    do_reset();
    check_eq("mid_err_cleared", 256'(err_underflow), 256'(0));
    in_valid  = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check_eq("mid_pre_valid",    256'(out_valid), 256'(1));
    check_eq("mid_pre_tag",      256'(out_tag),   256'(3));
    check_eq("mid_pre_inflight", 256'(inflight),  256'(3));
    reset = 1'b1;
    #1;
    check_eq("mid_async_valid",    256'(out_valid),   256'(0));
    check_eq("mid_async_inflight", 256'(inflight),    256'(0));
    check_eq("mid_async_payload",  256'(out_payload), 256'(0));
    check_eq("mid_async_ready",    256'(in_ready),    256'(0));
    tick();
    reset      = 1'b0;
    in_valid   = NS'(4'b1010);
    resp_valid = 1'b1;
    resp_tag   = TAG_W'(3);
    #1;
    check_eq("mid_first_grant", 256'(in_ready), 256'(oh(1)));
    tick();
    resp_valid = 1'b0;
    check_eq("mid_out_tag",     256'(out_tag),       256'(1));
    check_eq("mid_out_payload", 256'(out_payload),   256'(pl(1, 0)));
    check_eq("mid_stale_err",   256'(err_underflow), 256'(1));
    check_eq("mid_inflight",    256'(inflight),      256'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
